// File: rtl/mac_pipe_arbiter_if.sv
// Signal bundle between the multiply-add arbiter and its environment:
// requesters, the external A*B+C pipeline and the tagged result port.
interface mac_pipe_arbiter_if #(
   parameter int WIDTH     = 8,
   parameter int OUT_WIDTH = 16,
   parameter int NREQ      = 4,
   parameter int IDW       = 2
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*WIDTH-1:0] req_c;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      mul_a;
   logic [WIDTH-1:0]      mul_b;
   logic [WIDTH-1:0]      mul_c;
   logic [OUT_WIDTH-1:0]  mul_data;
   logic                  res_valid;
   logic [IDW-1:0]        res_id;
   logic [OUT_WIDTH-1:0]  res_data;
   logic                  flush;
   logic                  flush_done;
   logic                  busy;

   // environment side: requesters, pipeline and result consumer
   modport master (
      output req_valid, req_a, req_b, req_c, mul_data, flush,
      input  req_ready, mul_a, mul_b, mul_c, res_valid, res_id, res_data,
             flush_done, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, req_c, mul_data, flush,
      output req_ready, mul_a, mul_b, mul_c, res_valid, res_id, res_data,
             flush_done, busy
   );
endinterface

// File: rtl/mac_pipe_arbiter.sv
// Round-robin arbiter sharing one external 3-stage A*B+C pipeline among NREQ
// requesters; tags each issue and returns the result with its requester id.
module mac_pipe_arbiter #(
   parameter int WIDTH     = 8,
   parameter int OUT_WIDTH = 16,
   parameter int NREQ      = 4,
   parameter int IDW       = 2
) (
   input  logic              clk,
   input  logic              reset,
   mac_pipe_arbiter_if.slave bus
);
   // state | meaning
   // RUN   | grants allowed; flush sampled high moves to DRAIN
   // DRAIN | no grants; wait until nothing is in flight
   // DONE  | flush_done high for one cycle, then back to RUN
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int NTAG = 4;

   state_t               state;
   state_t               state_nxt;
   logic                 grant_en;
   logic                 flush_done;
   logic [IDW-1:0]       last_grant;
   logic [IDW:0]         cand;
   logic [NREQ-1:0]      grant;
   logic [IDW-1:0]       grant_id;
   logic [NREQ-1:0]      req_ready;
   logic                 xfer;
   logic [WIDTH-1:0]     mul_a;
   logic [WIDTH-1:0]     mul_b;
   logic [WIDTH-1:0]     mul_c;
   logic [WIDTH-1:0]     c_hold;
   logic [NTAG-1:0]      tag_v;
   logic [IDW-1:0]       tag_id [NTAG];
   logic                 res_valid;
   logic [IDW-1:0]       res_id;
   logic [OUT_WIDTH-1:0] res_data;
   logic                 busy;

   // Scan from lowest to highest priority so the highest-priority valid wins.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      cand     = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = {1'b0, last_grant} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (bus.req_valid[cand[IDW-1:0]]) begin
            grant                = '0;
            grant[cand[IDW-1:0]] = 1'b1;
            grant_id             = cand[IDW-1:0];
         end
      end
   end

   assign req_ready = grant_en ? grant : '0;
   assign xfer      = |req_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      grant_en   = 1'b0;
      flush_done = 1'b0;
      case (state)
         RUN: begin
            grant_en = !reset;
            if (bus.flush) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!busy) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            flush_done = 1'b1;
            state_nxt  = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   // C trails A/B by one cycle so it meets the pipeline's stage-2 adder.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= IDW'(NREQ - 1);
         mul_a      <= '0;
         mul_b      <= '0;
         mul_c      <= '0;
         c_hold     <= '0;
      end else begin
         if (xfer) begin
            last_grant <= grant_id;
            mul_a      <= bus.req_a[grant_id*WIDTH +: WIDTH];
            mul_b      <= bus.req_b[grant_id*WIDTH +: WIDTH];
            c_hold     <= bus.req_c[grant_id*WIDTH +: WIDTH];
         end
         mul_c <= c_hold;
      end
   end

   // Tag stage NTAG lines up with mul_data holding that operation's result.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_v     <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_data  <= '0;
         for (int k = 0; k < NTAG; k++) begin
            tag_id[k] <= '0;
         end
      end else begin
         tag_v     <= {tag_v[NTAG-2:0], xfer};
         tag_id[0] <= grant_id;
         for (int k = 1; k < NTAG; k++) begin
            tag_id[k] <= tag_id[k-1];
         end
         res_valid <= tag_v[NTAG-1];
         if (tag_v[NTAG-1]) begin
            res_id   <= tag_id[NTAG-1];
            res_data <= bus.mul_data;
         end
      end
   end

   // Stage-1 valid also covers the C operand still waiting in c_hold.
   assign busy = |tag_v;

   assign bus.req_ready  = req_ready;
   assign bus.mul_a      = mul_a;
   assign bus.mul_b      = mul_b;
   assign bus.mul_c      = mul_c;
   assign bus.res_valid  = res_valid;
   assign bus.res_id     = res_id;
   assign bus.res_data   = res_data;
   assign bus.flush_done = flush_done;
   assign bus.busy       = busy;
endmodule

// File: tb/tb_mac_pipe_arbiter.sv
// Bench for mac_pipe_arbiter: table vectors, hand-written corner sequences and
// random traffic against a queue-based scoreboard of tagged results.
module tb_mac_pipe_arbiter;
   localparam int WIDTH     = 8;
   localparam int OUT_WIDTH = 16;
   localparam int NREQ      = 4;
   localparam int IDW       = 2;
   localparam int OW2       = 12;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mac_pipe_arbiter_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();
   mac_pipe_arbiter_if #(.WIDTH(WIDTH), .OUT_WIDTH(OW2), .NREQ(NREQ), .IDW(IDW)) bus2 ();

   mac_pipe_arbiter #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   mac_pipe_arbiter #(.WIDTH(WIDTH), .OUT_WIDTH(OW2), .NREQ(NREQ), .IDW(IDW)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2));

   logic [NREQ-1:0]       rv  = '0;
   logic [NREQ-1:0]       rv2 = '0;
   logic [NREQ*WIDTH-1:0] ra  = '0, rb  = '0, rc  = '0;
   logic [NREQ*WIDTH-1:0] ra2 = '0, rb2 = '0, rc2 = '0;
   logic                  fl  = 1'b0;

   assign bus.req_valid  = rv;
   assign bus.req_a      = ra;
   assign bus.req_b      = rb;
   assign bus.req_c      = rc;
   assign bus.flush      = fl;
   assign bus2.req_valid = rv2;
   assign bus2.req_a     = ra2;
   assign bus2.req_b     = rb2;
   assign bus2.req_c     = rc2;
   assign bus2.flush     = 1'b0;

   // external pipelines: A*B at edge 1, +C at edge 2, output register at edge 3
   logic [OUT_WIDTH-1:0] p1, p2, p3;
   logic [OW2-1:0]       q1, q2, q3;
   always @(posedge clk) begin
      p1 <= OUT_WIDTH'(32'(bus.mul_a) * 32'(bus.mul_b));
      p2 <= p1 + OUT_WIDTH'(bus.mul_c);
      p3 <= p2;
      q1 <= OW2'(32'(bus2.mul_a) * 32'(bus2.mul_b));
      q2 <= q1 + OW2'(bus2.mul_c);
      q3 <= q2;
   end
   assign bus.mul_data  = p3;
   assign bus2.mul_data = q3;

   int n_chk  = 0;
   int n_fail = 0;
   int mcyc   = 0;
   always @(posedge clk) mcyc <= mcyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, mcyc);
      end
   endtask

   // Scoreboard: each transfer yields one result exactly 4 edges later.
   typedef struct {
      int due;
      int id;
      int data;
   } exp_t;
   exp_t q[$];
   exp_t e;
   logic bexp;

   always @(negedge clk) begin
      bexp = 1'b0;
      foreach (q[j]) if (q[j].due - 4 <= mcyc && mcyc < q[j].due) bexp = 1'b1;
      chk("mon_busy", 32'(bus.busy), 32'(bexp));
      if (q.size() > 0 && q[0].due == mcyc) begin
         chk("mon_res_valid", 32'(bus.res_valid), 32'd1);
         chk("mon_res_id", 32'(bus.res_id), 32'(q[0].id));
         chk("mon_res_data", 32'(bus.res_data), 32'(q[0].data));
         void'(q.pop_front());
      end else begin
         chk("mon_res_idle", 32'(bus.res_valid), 32'd0);
      end
      if (reset) begin
         q.delete();
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               e.due  = mcyc + 5;
               e.id   = i;
               e.data = (int'(ra[i*WIDTH +: WIDTH]) * int'(rb[i*WIDTH +: WIDTH])
                         + int'(rc[i*WIDTH +: WIDTH])) % (1 << OUT_WIDTH);
               q.push_back(e);
            end
         end
      end
   end

   function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return NREQ'(1) << ((last + k) % NREQ);
      end
      return '0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input int a, input int b, input int c);
      rv[i]               = v;
      ra[i*WIDTH +: WIDTH] = WIDTH'(a);
      rb[i*WIDTH +: WIDTH] = WIDTH'(b);
      rc[i*WIDTH +: WIDTH] = WIDTH'(c);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   typedef struct {
      int id;
      int a;
      int b;
      int c;
      int data;
   } vec_t;
   vec_t tbl[6];

   logic [NREQ-1:0] exp_rdy;
   int              last;
   int              nres;
   logic            found;

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit expired, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{0, 3, 4, 5, 17};
      tbl[1] = '{3, 255, 255, 255, 65280};
      tbl[2] = '{1, 10, 10, 1, 101};
      tbl[3] = '{2, 0, 0, 0, 0};
      tbl[4] = '{2, 200, 3, 7, 607};
      tbl[5] = '{1, 0, 255, 200, 200};

      // reset values, with every requester asking
      rv = '1;
      tick();
      tick();
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_res_id", 32'(bus.res_id), 32'd0);
      chk("rst_res_data", 32'(bus.res_data), 32'd0);
      chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_mul_a", 32'(bus.mul_a), 32'd0);
      chk("rst_mul_b", 32'(bus.mul_b), 32'd0);
      chk("rst_mul_c", 32'(bus.mul_c), 32'd0);
      tick();
      rv    = '0;
      reset = 1'b0;

      // single isolated requests with exact busy window and latency
      foreach (tbl[n]) begin
         tick();
         set_req(tbl[n].id, 1'b1, tbl[n].a, tbl[n].b, tbl[n].c);
         @(negedge clk);
         chk("tbl_ready", 32'(bus.req_ready), 32'(NREQ'(1) << tbl[n].id));
         tick();
         set_req(tbl[n].id, 1'b0, tbl[n].a, tbl[n].b, tbl[n].c);
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("tbl_busy", 32'(bus.busy), 32'(k < 4));
         end
         chk("tbl_res_valid", 32'(bus.res_valid), 32'd1);
         chk("tbl_res_id", 32'(bus.res_id), 32'(tbl[n].id));
         chk("tbl_res_data", 32'(bus.res_data), 32'(tbl[n].data));
      end

      // round robin with all requesters holding valid
      tick();
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 1, 2, i);
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         if (k < 6) chk("rr_ready", 32'(bus.req_ready), 32'(NREQ'(1) << (k % NREQ)));
         else       chk("rr_ready_idle", 32'(bus.req_ready), 32'd0);
         if (k >= 5) begin
            chk("rr_res_valid", 32'(bus.res_valid), 32'd1);
            chk("rr_res_id", 32'(bus.res_id), 32'((k - 5) % NREQ));
            chk("rr_res_data", 32'(bus.res_data), 32'(((k - 5) % NREQ + 1) * 2 + (k - 5) % NREQ));
         end
         tick();
         if (k == 5) rv = '0;
      end

      // C must pair with its own A*B on back-to-back issues
      tick();
      set_req(1, 1'b1, 10, 10, 1);
      @(negedge clk);
      chk("calign_ready1", 32'(bus.req_ready), 32'h2);
      tick();
      set_req(1, 1'b0, 10, 10, 1);
      set_req(2, 1'b1, 2, 2, 100);
      @(negedge clk);
      chk("calign_ready2", 32'(bus.req_ready), 32'h4);
      tick();
      set_req(2, 1'b0, 2, 2, 100);
      repeat (3) @(negedge clk);
      @(negedge clk);
      chk("calign_first", 32'(bus.res_data), 32'd101);
      @(negedge clk);
      chk("calign_second", 32'(bus.res_data), 32'd104);

      // narrow result width wraps: 64*64+1 mod 4096
      tick();
      rv2[0] = 1'b1;
      ra2[WIDTH-1:0] = 8'd64;
      rb2[WIDTH-1:0] = 8'd64;
      rc2[WIDTH-1:0] = 8'd1;
      @(negedge clk);
      chk("ow12_ready", 32'(bus2.req_ready), 32'd1);
      tick();
      rv2   = '0;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (bus2.res_valid) begin
            found = 1'b1;
            chk("ow12_data", 32'(bus2.res_data), 32'd1);
         end
      end
      chk("ow12_seen", 32'(found), 32'd1);

      // flush raised with the third grant
      tick();
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 7 + i, 3, i);
      @(negedge clk);
      chk("flush_g0", 32'(bus.req_ready), 32'h1);
      tick();
      @(negedge clk);
      chk("flush_g1", 32'(bus.req_ready), 32'h2);
      tick();
      fl = 1'b1;
      @(negedge clk);
      chk("flush_g2", 32'(bus.req_ready), 32'h4);
      tick();
      fl   = 1'b0;
      nres = 0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (bus.res_valid) nres++;
         if (k < 6) chk("flush_no_grant", 32'(bus.req_ready), 32'd0);
         else       chk("flush_resume", 32'(bus.req_ready), 32'h8);
         chk("flush_done_pulse", 32'(bus.flush_done), 32'(k == 5));
         tick();
      end
      rv = '0;
      chk("flush_results", 32'(nres), 32'd3);

      // flush held high: second pulse three cycles after the first
      tick();
      fl    = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (bus.flush_done) found = 1'b1;
         else tick();
      end
      chk("reflush_first", 32'(found), 32'd1);
      for (int k = 1; k <= 3; k++) begin
         tick();
         @(negedge clk);
         chk("reflush_second", 32'(bus.flush_done), 32'(k == 3));
      end
      tick();
      fl = 1'b0;
      tick();

      // reset while two operations are in flight
      set_req(1, 1'b1, 5, 6, 7);
      set_req(2, 1'b1, 8, 9, 10);
      @(negedge clk);
      chk("mid_issue1", 32'(|bus.req_ready), 32'd1);
      tick();
      @(negedge clk);
      chk("mid_issue2", 32'(|bus.req_ready), 32'd1);
      tick();
      rv    = '0;
      reset = 1'b1;
      @(negedge clk);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("mid_no_result", 32'(bus.res_valid), 32'd0);
         chk("mid_not_busy", 32'(bus.busy), 32'd0);
         tick();
      end
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i, i, i);
      @(negedge clk);
      chk("mid_ptr_reset", 32'(bus.req_ready), 32'h1);
      tick();
      rv = '0;

      // random traffic against the round-robin model and scoreboard
      tick();
      do_reset();
      last = NREQ - 1;
      for (int t = 0; t < 300; t++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!rv[i] && $urandom_range(0, 2) == 0) begin
               set_req(i, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)));
            end
         end
         @(negedge clk);
         exp_rdy = rr_pick(rv, last);
         chk("rand_ready", 32'(bus.req_ready), 32'(exp_rdy));
         tick();
         for (int i = 0; i < NREQ; i++) begin
            if (exp_rdy[i]) begin
               rv[i] = 1'b0;
               last  = i;
            end
         end
      end
      rv = '0;
      repeat (8) tick();
      chk("drain_empty", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
